// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the clear-engine state encoding, the zero-register index and the address-width function.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int REG_ZERO = 0;

    // Ceiling log2, used to size address fields from DEPTH.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine for regfile_mp: sweeps the array one entry per cycle.
// The array is usable (ready=1) only while the engine is idle.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    localparam int AW = clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    state_t        state, state_nx;
    logic [AW-1:0] idx, idx_nx;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nx = CLEAR;
                    idx_nx   = '0;
                end
            end
            CLEAR: begin
                if (idx == AW'(DEPTH - 1)) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + AW'(1);
                end
            end
            default: begin
                state_nx = CLEAR;
                idx_nx   = '0;
            end
        endcase
    end

    assign ready   = (state == IDLE);
    assign clr_we  = (state == CLEAR);
    assign clr_idx = idx;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-to-read bypass,
// per-register pending scoreboard and a sequential clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    localparam int AW = clog2(DEPTH)
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    output logic                     ready,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr
);

    logic              clr_we;
    logic [AW-1:0]     clr_idx;
    logic [NUM_WR-1:0] wr_ok;
    logic              iss_ok;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .ready   (ready),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    // Writes and issues only count while usable and never target the zero register.
    always_comb begin
        wr_ok = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_ok[w] = ready && wr_en[w] && (wr_addr[w*AW +: AW] != AW'(REG_ZERO));
        end
    end

    assign iss_ok = ready && iss_en && (iss_addr != AW'(REG_ZERO));

    // NOTE: the array has no reset; the clear engine zeroes it so it can map onto SRAM.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_ok[w]) begin
                mem[wr_addr[w*AW +: AW]] <= wr_data[w*DATA_W +: DATA_W];
            end
        end
    end

    // Issue is applied last: a same-cycle issue outranks the write as the newer producer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (clr_we) begin
                pending[clr_idx] <= 1'b0;
            end
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w]) begin
                    pending[wr_addr[w*AW +: AW]] <= 1'b0;
                end
            end
            if (iss_ok) begin
                pending[iss_addr] <= 1'b1;
            end
        end
    end

    // Read ports: array value, overridden by any same-cycle write (highest port last).
    always_comb begin
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] rv;
        logic              rp;
        rd_data = '0;
        rd_pend = '0;
        ra      = '0;
        rv      = '0;
        rp      = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra = rd_addr[p*AW +: AW];
            rv = mem[ra];
            rp = pending[ra];
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w] && (wr_addr[w*AW +: AW] == ra)) begin
                    rv = wr_data[w*DATA_W +: DATA_W];
                    rp = 1'b0;
                end
            end
            if (ready && (ra != AW'(REG_ZERO))) begin
                rd_data[p*DATA_W +: DATA_W] = rv;
                rd_pend[p]                  = rp;
            end
        end
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined MIPS core, replacing the fixed 32×32, 2-read/1-write file. Adds configurable width, depth and port counts, same-cycle write-to-read bypass, a per-register pending scoreboard for hazard detection, and a sequential clear engine that zeroes the array one entry per cycle, so the array maps to SRAM-style storage. Sits between decode (reads, issue marking) and writeback (writes).

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers (≥2, power of two); AW = clog2(DEPTH)
- NUM_RD, 2, read ports
- NUM_WR, 1, write ports (1–4)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- clr_req  in  1  request a full array clear (sampled only when ready=1)
- ready  out  1  high when the clear engine is idle and the array is usable
- rd_addr  in  NUM_RD*AW  packed read addresses, port p at [p*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  packed combinational read data
- rd_pend  out  NUM_RD  pending flag of each read address
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR*AW  packed write addresses
- wr_data  in  NUM_WR*DATA_W  packed write data
- iss_en  in  1  mark iss_addr pending (producer issued)
- iss_addr  in  AW  destination being issued

## Operation
- Entry 0 hardwired: reads return 0, rd_pend=0, writes and issues to 0 discarded.
- Write: wr_en[w] with wr_addr≠0 updates the entry at the rising edge. Several ports to the same address: highest port index wins.
- Read: rd_data[p] = storage[rd_addr[p]], except when a write to the same nonzero address is enabled in the same cycle; then it returns that write's data (highest-index port wins).
- Scoreboard: one pending bit per entry. iss_en sets pending[iss_addr] and any enabled write clears pending[wr_addr]. Issue and write to the same address in the same cycle: pending ends set, because the issue is the newer producer.
- rd_pend[p] = pending[rd_addr[p]] & ~(same-cycle enabled write to rd_addr[p]).
- Clear engine FSM, states IDLE and CLEAR, index counter idx (AW bits):
  - rst → CLEAR, idx=0.
  - IDLE & clr_req → CLEAR, idx=0.
  - CLEAR: each cycle write 0 to entry idx and clear pending[idx]. When idx=DEPTH-1, go to IDLE; otherwise idx+1.
- While ready=0:
  - wr_en, iss_en and clr_req are ignored.
  - rd_data=0 and rd_pend=0 on all ports.
- rst asserted mid-clear restarts the sweep at idx=0.

## Timing
- Reset values: ready=0, rd_data=0, rd_pend=0. The FSM is in CLEAR and all pending bits are cleared by the sweep.
- Clear latency: rst or accepted clr_req at edge N → ready=1 after edge N+DEPTH. For DEPTH=32, ready rises 32 cycles after rst deasserts.
- Write → read latency: 0 cycles via bypass. The value is held in the array from the next edge.
- Issue → rd_pend visible: 1 cycle (pending is registered). Write → rd_pend low: same cycle via bypass term.
- clr_req arriving on the same edge as writes: the writes are performed and the clear starts on the following cycle.

## Structure
- Package regfile_pkg:
  - state enum {IDLE, CLEAR}
  - constant REG_ZERO=0
  - address-width function clog2
- Sub-module regfile_clear_fsm: FSM, idx counter, ready, clear-write strobe.
- The top level holds storage, write-priority resolution, bypass muxes and the scoreboard.

## Test plan
- Reset sweep, default parameters:
  - pulse rst 1 cycle → ready=0 for exactly 32 cycles, then 1;
  - all reads return 0;
  - writes attempted during the sweep leave no effect.
- Write/bypass:
  - write 0xDEADBEEF to r5 while rd_addr[0]=5 → rd_data[0]=0xDEADBEEF in the same cycle;
  - next cycle, with no write, still 0xDEADBEEF.
- Zero register: write 0x12345678 to r0 and issue r0 → rd_data=0 and rd_pend=0.
- Multi-write (NUM_WR=2): both ports write r7 with 0xA and 0xB → r7 reads 0xB.
- Scoreboard:
  - iss r9 → rd_pend=1 on the next cycle;
  - write r9 → rd_pend=0 in the write cycle;
  - simultaneous iss r9 and write r9 → rd_pend=1 the cycle after.
- Mid-clear restart:
  - clr_req, then rst at sweep idx=10 → ready rises 32 cycles after rst;
  - all entries read 0, all pending bits clear.
